// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one double dabble converter between two requesters.
// Optional result cache per requester: define BCD_ARB_CACHE_EN.
module bcd_convert_arbiter #(
  parameter int INPUT_BITS     = 8,
  parameter int OUTPUT_DIGITS  = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Req0_i,
  input  logic [INPUT_BITS-1:0]      Data0_i,
  input  logic                       Req1_i,
  input  logic [INPUT_BITS-1:0]      Data1_i,
  output logic                       Ack0_o,
  output logic                       Ack1_o,
  output logic [4*OUTPUT_DIGITS-1:0] Result_o,
  output logic                       Error_o,
  output logic                       DdStart_o,
  output logic [INPUT_BITS-1:0]      DdData_o,
  input  logic                       DdDone_i,
  input  logic [4*OUTPUT_DIGITS-1:0] DdResult_i
);

  localparam int RW = 4*OUTPUT_DIGITS;
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DELIVER} state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  gnt_q, gnt_d;
  logic [INPUT_BITS-1:0] operand_q, operand_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RW-1:0]         result_q, result_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  err_q, err_d;
  logic                  start_q, start_d;

  logic                  sel;
  logic [INPUT_BITS-1:0] sel_data;

`ifdef BCD_ARB_CACHE_EN
  logic [1:0]                 cvalid_q, cvalid_d;
  logic [1:0][INPUT_BITS-1:0] cop_q, cop_d;
  logic [1:0][RW-1:0]         cres_q, cres_d;
  logic                       hit;
`endif

  always_comb begin
    sel      = (Req0_i && Req1_i) ? rr_q : Req1_i;
    sel_data = sel ? Data1_i : Data0_i;
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    err_d     = 1'b0;
    start_d   = 1'b0;
`ifdef BCD_ARB_CACHE_EN
    cvalid_d  = cvalid_q;
    cop_d     = cop_q;
    cres_d    = cres_q;
    hit       = cvalid_q[sel] && (cop_q[sel] == sel_data);
`endif
    case (state_q)
      IDLE: begin
        if (Req0_i || Req1_i) begin
          gnt_d     = sel;
          operand_d = sel_data;
`ifdef BCD_ARB_CACHE_EN
          if (hit) begin
            result_d = cres_q[sel];
            ack0_d   = ~sel;
            ack1_d   = sel;
            state_d  = DELIVER;
          end else begin
            start_d = 1'b1;
            state_d = START;
          end
`else
          start_d = 1'b1;
          state_d = START;
`endif
        end
      end
      START: begin
        // Counter holds cycles elapsed since DdStart_o, so expiry lands
        // exactly TIMEOUT_CYCLES after the start pulse.
        cnt_d   = CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (DdDone_i) begin
          result_d = DdResult_i;
          ack0_d   = ~gnt_q;
          ack1_d   = gnt_q;
          state_d  = DELIVER;
`ifdef BCD_ARB_CACHE_EN
          cvalid_d[gnt_q] = 1'b1;
          cop_d[gnt_q]    = operand_q;
          cres_d[gnt_q]   = DdResult_i;
`endif
        end else if (cnt_q == CW'(TIMEOUT_CYCLES-1)) begin
          result_d = '1;
          err_d    = 1'b1;
          ack0_d   = ~gnt_q;
          ack1_d   = gnt_q;
          state_d  = DELIVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DELIVER: begin
        rr_d    = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      operand_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
`ifdef BCD_ARB_CACHE_EN
      cvalid_q  <= '0;
      cop_q     <= '0;
      cres_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      err_q     <= err_d;
      start_q   <= start_d;
`ifdef BCD_ARB_CACHE_EN
      cvalid_q  <= cvalid_d;
      cop_q     <= cop_d;
      cres_q    <= cres_d;
`endif
    end
  end

  assign Ack0_o    = ack0_q;
  assign Ack1_o    = ack1_q;
  assign Result_o  = result_q;
  assign Error_o   = err_q;
  assign DdStart_o = start_q;
  assign DdData_o  = operand_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Scoreboard bench for bcd_convert_arbiter with a behavioural converter model.
module tb_bcd_convert_arbiter;
  localparam int IB = 8;
  localparam int OD = 3;
  localparam int RW = 4*OD;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Req0_i = 1'b0, Req1_i = 1'b0;
  logic [IB-1:0] Data0_i = '0, Data1_i = '0;
  logic          Ack0_o, Ack1_o, Error_o, DdStart_o;
  logic [RW-1:0] Result_o;
  logic [IB-1:0] DdData_o;
  logic          dd_done = 1'b0;
  logic [RW-1:0] dd_res = '0;

  bcd_convert_arbiter #(.INPUT_BITS(IB), .OUTPUT_DIGITS(OD), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .Req0_i(Req0_i), .Data0_i(Data0_i), .Req1_i(Req1_i), .Data1_i(Data1_i),
    .Ack0_o(Ack0_o), .Ack1_o(Ack1_o), .Result_o(Result_o), .Error_o(Error_o),
    .DdStart_o(DdStart_o), .DdData_o(DdData_o),
    .DdDone_i(dd_done), .DdResult_i(dd_res)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            id;
    logic [RW-1:0] res;
    bit            err;
    int            lat_start;
    int            max_req;
  } exp_t;

  exp_t          sb[$];
  logic [IB-1:0] exp_op[$];
  int            req_cyc[2];

  bit            hang = 1'b0;
  int            dly = 4;
  bit            pend = 1'b0;
  int            mcnt = 0;
  logic [IB-1:0] mop = '0;
  int            starts = 0;
  int            last_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  function automatic logic [RW-1:0] bcd(input logic [IB-1:0] v);
    int d;
    d = int'(v);
    return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  function automatic void push(input bit id, input logic [RW-1:0] res, input bit err,
                               input int lat_start, input int max_req);
    exp_t e;
    e.id = id; e.res = res; e.err = err; e.lat_start = lat_start; e.max_req = max_req;
    sb.push_back(e);
  endfunction

  // Converter model
  initial forever begin
    @(negedge clk);
    if (dd_done) dd_done = 1'b0;
    if (!rst_n) pend = 1'b0;
    else if (DdStart_o) begin
      starts++;
      last_start = cyc;
      mop = DdData_o;
      pend = 1'b1;
      mcnt = 0;
      if (exp_op.size() == 0) fail("start_operand", "unexpected DdStart_o");
      else chk("start_operand", 32'(DdData_o), 32'(exp_op.pop_front()));
    end else if (pend) begin
      mcnt++;
      chk("operand_stable", 32'(DdData_o), 32'(mop));
      if (!hang && mcnt >= dly) begin
        dd_done = 1'b1;
        dd_res  = bcd(mop);
        pend    = 1'b0;
      end
    end
    if (Ack0_o || Ack1_o) pend = 1'b0;
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (Ack0_o || Ack1_o) begin
        exp_t e;
        if (Ack0_o && Ack1_o) fail("ack_onehot", "both acks high");
        if (sb.size() == 0) fail("ack_unexpected", "ack with empty scoreboard");
        else begin
          e = sb.pop_front();
          chk("ack_id", 32'(Ack1_o), 32'(e.id));
          chk("result", 32'(Result_o), 32'(e.res));
          chk("error", 32'(Error_o), 32'(e.err));
          if (e.lat_start > 0) chk("timeout_latency", 32'(cyc - last_start), 32'(e.lat_start));
          if (e.max_req > 0)
            chk("cache_latency_ok", 32'((cyc - req_cyc[e.id]) <= e.max_req), 32'd1);
        end
      end else if (Error_o) fail("error_without_ack", "Error_o high with no ack");
    end
  end

  task automatic hold_req(input bit id, input logic [IB-1:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    if (id) begin Req1_i = 1'b1; Data1_i = d; end
    else    begin Req0_i = 1'b1; Data0_i = d; end
    req_cyc[id] = cyc;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (id ? Ack1_o : Ack0_o) got = 1'b1;
    end
    if (id) Req1_i = 1'b0; else Req0_i = 1'b0;
    if (!got) fail("req_timeout", $sformatf("no ack for requester %0d", id));
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && (sb.size() != 0 || exp_op.size() != 0); i++) @(negedge clk);
    if (sb.size() != 0 || exp_op.size() != 0) fail("drain", "expected responses outstanding");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 50 && !DdStart_o; i++) @(negedge clk);
    if (!DdStart_o) fail("wait_start", "DdStart_o never seen");
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ack0"}, 32'(Ack0_o), 32'd0);
    chk({tag, "_ack1"}, 32'(Ack1_o), 32'd0);
    chk({tag, "_result"}, 32'(Result_o), 32'd0);
    chk({tag, "_error"}, 32'(Error_o), 32'd0);
    chk({tag, "_start"}, 32'(DdStart_o), 32'd0);
    chk({tag, "_ddata"}, 32'(DdData_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous pair from reset: requester 0 favoured
    push(1'b0, 12'h012, 1'b0, 0, 0); push(1'b1, 12'h034, 1'b0, 0, 0);
    exp_op.push_back(8'd12); exp_op.push_back(8'd34);
    fork hold_req(1'b0, 8'd12); hold_req(1'b1, 8'd34); join
    drain();

    // Single request, 10-cycle converter
    dly = 10;
    push(1'b0, 12'h255, 1'b0, 0, 0); exp_op.push_back(8'd255);
    hold_req(1'b0, 8'd255);
    drain();
    dly = 4;

    // Requester 0 served last, so requester 1 wins this pair
    push(1'b1, 12'h078, 1'b0, 0, 0); push(1'b0, 12'h056, 1'b0, 0, 0);
    exp_op.push_back(8'd78); exp_op.push_back(8'd56);
    fork hold_req(1'b0, 8'd56); hold_req(1'b1, 8'd78); join
    drain();

    // Converter hang: abort exactly TO cycles after start
    hang = 1'b1;
    push(1'b0, 12'hFFF, 1'b1, TO, 0); exp_op.push_back(8'd200);
    hold_req(1'b0, 8'd200);
    drain();
    hang = 1'b0;

    // Data change after grant is ignored
    push(1'b0, 12'h005, 1'b0, 0, 0); exp_op.push_back(8'd5);
    fork
      hold_req(1'b0, 8'd5);
      begin wait_start(); @(negedge clk); Data0_i = 8'd99; end
    join
    drain();

    // Reset during WAIT, held request restarts
    dly = 20;
    push(1'b0, 12'h077, 1'b0, 0, 0);
    exp_op.push_back(8'd77); exp_op.push_back(8'd77);
    fork
      hold_req(1'b0, 8'd77);
      begin
        wait_start();
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
      end
    join
    drain();
    dly = 4;

    // Requester 1 alone
    push(1'b1, 12'h099, 1'b0, 0, 0); exp_op.push_back(8'd99);
    hold_req(1'b1, 8'd99);
    drain();

    s = starts;
    push(1'b0, 12'h042, 1'b0, 0, 0); exp_op.push_back(8'd42);
    hold_req(1'b0, 8'd42);
    drain();
`ifdef BCD_ARB_CACHE_EN
    push(1'b0, 12'h042, 1'b0, 0, 2);
    hold_req(1'b0, 8'd42);
    drain();
    chk("cache_hit_no_start", 32'(starts - s), 32'd1);
    push(1'b0, 12'h043, 1'b0, 0, 0); exp_op.push_back(8'd43);
    hold_req(1'b0, 8'd43);
    drain();
    chk("cache_miss_runs", 32'(starts - s), 32'd2);
`else
    push(1'b0, 12'h042, 1'b0, 0, 0); exp_op.push_back(8'd42);
    hold_req(1'b0, 8'd42);
    drain();
    chk("repeat_runs_converter", 32'(starts - s), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_convert_arbiter.md
Name: bcd_convert_arbiter

Overview:
Shares one sequential double dabble converter between two requesters, for example the encoder counter value and a secondary display value. Arbitrates requests round-robin and sequences the converter's start/done handshake. Returns the packed BCD result to the granted requester and flags converter hangs with a timeout. Sits between the value sources and the 7-segment display driver in top.

Parameters:
INPUT_BITS, 8, width of binary value to convert
OUTPUT_DIGITS, 3, BCD digits produced by converter (result width 4*OUTPUT_DIGITS)
TIMEOUT_CYCLES, 64, max cycles from DdStart_o to DdDone_i before abort; must be >= INPUT_BITS+2

Ports:
Clock  input  1  system clock
Reset  input  1  asynchronous, active-low reset
Req0_i  input  1  requester 0 conversion request, level, held until Ack0_o
Data0_i  input  INPUT_BITS  requester 0 binary value
Req1_i  input  1  requester 1 conversion request, level, held until Ack1_o
Data1_i  input  INPUT_BITS  requester 1 binary value
Ack0_o  output  1  one-cycle pulse: result for requester 0 valid on Result_o
Ack1_o  output  1  one-cycle pulse: result for requester 1 valid on Result_o
Result_o  output  4*OUTPUT_DIGITS  packed BCD result, digit 0 in LSBs
Error_o  output  1  one-cycle pulse accompanying Ack on timeout abort
DdStart_o  output  1  one-cycle start pulse to converter
DdData_o  output  INPUT_BITS  binary operand to converter, stable from start until done
DdDone_i  input  1  converter done pulse
DdResult_i  input  4*OUTPUT_DIGITS  converter BCD result, valid when DdDone_i=1

Behaviour:
- Reset (Reset=0, asynchronous): state IDLE; all outputs 0; round-robin pointer favours requester 0; operand register 0.
- FSM states: IDLE, START, WAIT, DELIVER.
- IDLE: if any Req high, grant per round-robin. Only one requesting -> that one. Both requesting -> the one not served last. Latch the granted Data into operand register (DdData_o) and the grant id; go to START.
- START: DdStart_o=1 for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT: count cycles. On DdDone_i=1, latch DdResult_i into Result_o and go to DELIVER. If count reaches TIMEOUT_CYCLES with no done, set Result_o to all 0xF nibbles, flag error, go to DELIVER. DdDone_i in the same cycle as expiry counts as success.
- DELIVER: pulse Ack of the granted requester for one cycle; Error_o=1 in the same cycle if aborted; flip round-robin pointer to the other requester; return to IDLE.
- Latency, request to Ack with an immediate grant: 3 cycles plus converter time (IDLE grant, START, WAIT..done, DELIVER).
- Result_o holds its last value between deliveries. Requesters sample it on their Ack.
- Data changes after grant are ignored; the operand is latched at grant.
- Req dropped after grant: conversion completes and Ack still pulses; no cancellation.
- Req still high in the cycle after Ack: treated as a new request.
- DdDone_i outside WAIT: ignored.
- Reset mid-conversion: FSM aborts to IDLE asynchronously; no Ack issued.
- Never more than one Ack high at once; Ack0_o and Ack1_o never both 1.

Optional Feature:
BCD_ARB_CACHE_EN
- Defined: stores the last operand and result per requester, with a valid bit cleared by reset. In IDLE, if the granted Data equals that requester's cached operand and the cache is valid, skip START/WAIT and go directly to DELIVER with the cached result. Latency is 2 cycles and no DdStart_o pulse is issued. Timeout results are not cached.
- Undefined: every request runs the converter; no cache registers exist.

Test Plan:
- Req0_i=1, Data0_i=8'd255, model done after 10 cycles returning 12'h255 -> one DdStart_o with DdData_o=255; Ack0_o pulse 1 cycle with Result_o=12'h255; Error_o=0.
- Req0_i and Req1_i raised in the same cycle (Data0=12, Data1=34), held until each Ack -> Ack0_o first with 12'h012, then Ack1_o with 12'h034. Next simultaneous pair -> order alternates, requester 1 first.
- Converter model never asserts done, TIMEOUT_CYCLES=64 -> Ack0_o and Error_o together exactly 64 cycles after DdStart_o; Result_o=12'hFFF.
- Reset driven low during WAIT, then released -> all outputs 0 immediately; no Ack. The still-held Req restarts the conversion from IDLE.
- Data0_i changed from 5 to 99 one cycle after grant -> DdData_o stays 5; Result_o=12'h005.
- With BCD_ARB_CACHE_EN: convert 42 twice from requester 0 -> second Ack arrives 2 cycles after Req with 12'h042 and no DdStart_o. Converting 43 next -> converter runs.
